// File: rtl/mvme_ucode_engine.sv
// rtl/mvme_ucode_engine.sv - microprogrammed 4-term fixed-point dot-product engine
// Host loads program and register file while idle; the engine issues one MAC per cycle with RAW interlock.
module mvme_ucode_engine #(
    parameter int W       = 35,
    parameter int FRAC    = 24,
    parameter int NREG    = 16,
    parameter int NINST   = 32,
    parameter int MAC_LAT = 10,
    localparam int RW     = $clog2(NREG),
    localparam int PW     = $clog2(NINST),
    localparam int IW     = 8*RW + RW + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [IW-1:0] prog_wdata,
    input  logic          rf_we,
    input  logic [RW-1:0] rf_waddr,
    input  logic [W-1:0]  rf_wdata,
    input  logic [RW-1:0] rf_raddr,
    output logic [W-1:0]  rf_rdata,
    output logic          wr_rej,
    output logic          overload,
    input  logic          clr_ovl,
    output logic [15:0]   cyc_cnt
);
    // Pipe stages 1..MAC_LAT-1; the last stage writes rf so the result is readable MAC_LAT cycles after issue.
    localparam int NST = MAC_LAT - 1;
    localparam int AW  = 2*W + 2;
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]  rf   [NREG];
    logic [IW-1:0] prog [NINST];
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
    logic          inst_last, inst_dep;
    logic [RW-1:0] inst_dst;
    logic          issue, inflight, wb;
    logic [15:0]   run_cnt;

    logic signed [W-1:0]  opa [4];
    logic signed [W-1:0]  opb [4];
    logic signed [AW-1:0] acc, shifted;
    logic [W-1:0]         sat_res;
    logic                 sat_clip;

    logic [NST-1:0] pv, pclip;
    logic [RW-1:0]  pdst [NST];
    logic [W-1:0]   pres [NST];

    assign inst      = prog[pc];
    assign inst_last = inst[IW-1];
    assign inst_dep  = inst[IW-2];
    assign inst_dst  = inst[IW-3 -: RW];
    assign inflight  = |pv;
    assign wb        = pv[NST-1] && enable;
    assign rf_rdata  = rf[rf_raddr];

    always_ff @(posedge clk) begin
        if (rst || !enable) state <= S_IDLE;
        else                state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ISSUE;
            S_ISSUE: if (issue && (inst_last || pc == PW'(NINST-1))) state_nx = S_DRAIN;
            S_DRAIN: if (!inflight) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == S_ISSUE) || (state == S_DRAIN);
        done  = (state == S_DONE) && enable;
        issue = (state == S_ISSUE) && enable && !(inst_dep && inflight);
    end

    // Operand slots are packed a0,b0,a1,b1,... from the top of the instruction word.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            opa[k] = $signed(rf[inst[(7-2*k)*RW +: RW]]);
            opb[k] = $signed(rf[inst[(6-2*k)*RW +: RW]]);
        end
        acc = '0;
        for (int k = 0; k < 4; k++)
            acc = acc + AW'(opa[k]) * AW'(opb[k]);
        shifted = acc >>> FRAC;
        sat_clip = 1'b1;
        if (shifted > SAT_HI)      sat_res = SAT_HI[W-1:0];
        else if (shifted < SAT_LO) sat_res = SAT_LO[W-1:0];
        else begin
            sat_res  = shifted[W-1:0];
            sat_clip = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) pv <= '0;
        else begin
            pv[0] <= issue;
            for (int i = 1; i < NST; i++) pv[i] <= pv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pdst[0]  <= inst_dst;
        pres[0]  <= sat_res;
        pclip[0] <= sat_clip;
        for (int i = 1; i < NST; i++) begin
            pdst[i]  <= pdst[i-1];
            pres[i]  <= pres[i-1];
            pclip[i] <= pclip[i-1];
        end
    end

    // Host writes only land while idle, when the pipe is empty, so they never collide with writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (wb && pdst[NST-1] != '0) rf[pdst[NST-1]] <= pres[NST-1];
            if (rf_we && state == S_IDLE && rf_waddr != '0) rf[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) prog[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            run_cnt  <= '0;
            cyc_cnt  <= '0;
            wr_rej   <= 1'b0;
            overload <= 1'b0;
        end else begin
            wr_rej <= (rf_we || prog_we) && state != S_IDLE;
            if (state == S_IDLE)   pc <= '0;
            else if (issue)        pc <= pc + 1'b1;
            if (state == S_IDLE)   run_cnt <= 16'd1;
            else                   run_cnt <= run_cnt + 16'd1;
            if (enable && state == S_DRAIN && state_nx == S_DONE) cyc_cnt <= run_cnt + 16'd1;
            if (wb && pclip[NST-1]) overload <= 1'b1;
            else if (clr_ovl)       overload <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mvme_ucode_engine.sv
// tb/tb_mvme_ucode_engine.sv - self-checking bench for mvme_ucode_engine
// Reference model: wide-integer dot products in program order plus an issue-time schedule.
module tb_mvme_ucode_engine;
    localparam int     MAC_LAT = 10;
    localparam longint ONE     = 64'sd16777216;

    logic        clk = 1'b0;
    logic        rst, enable, start, prog_we, rf_we, clr_ovl;
    logic [4:0]  prog_addr;
    logic [37:0] prog_wdata;
    logic [3:0]  rf_waddr, rf_raddr;
    logic [34:0] rf_wdata, rf_rdata;
    logic        busy, done, wr_rej, overload;
    logic [15:0] cyc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [34:0] mrf [16];
    int m_dst [32];
    int m_dep [32];
    int m_last[32];
    int m_src [32][8];
    int last_cyc = 0;

    mvme_ucode_engine dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .busy(busy), .done(done),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .wr_rej(wr_rej),
        .overload(overload), .clr_ovl(clr_ovl), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_rf(input int idx, input logic [34:0] v);
        rf_we = 1'b1; rf_waddr = idx[3:0]; rf_wdata = v;
        tick;
        rf_we = 1'b0;
        if (idx != 0) mrf[idx] = v;
    endtask

    task automatic get_rf(input int idx, output logic signed [34:0] v);
        rf_raddr = idx[3:0];
        #1;
        v = rf_rdata;
    endtask

    task automatic set_instr(input int pc, input int last, input int dep, input int dst,
                             input int a0, input int b0, input int a1, input int b1,
                             input int a2, input int b2, input int a3, input int b3);
        m_last[pc] = last; m_dep[pc] = dep; m_dst[pc] = dst;
        m_src[pc][0] = a0; m_src[pc][1] = b0; m_src[pc][2] = a1; m_src[pc][3] = b1;
        m_src[pc][4] = a2; m_src[pc][5] = b2; m_src[pc][6] = a3; m_src[pc][7] = b3;
        prog_we = 1'b1; prog_addr = pc[4:0];
        prog_wdata = {last[0], dep[0], dst[3:0], a0[3:0], b0[3:0], a1[3:0], b1[3:0],
                      a2[3:0], b2[3:0], a3[3:0], b3[3:0]};
        tick;
        prog_we = 1'b0;
    endtask

    // Runs the model program: values in program order, issue times from the interlock rule.
    task automatic model_run(output int cyc, output bit ovl);
        logic signed [127:0] s, x, y, q;
        logic signed [127:0] hi, lo;
        int t, li;
        hi = (128'sd1 <<< 34) - 1;
        lo = -(128'sd1 <<< 34);
        t = 1; li = -1000; ovl = 0;
        for (int pc = 0; pc < 32; pc++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                x = mrf[m_src[pc][2*k]];
                y = mrf[m_src[pc][2*k+1]];
                s = s + x * y;
            end
            q = s >>> 24;
            if (q > hi) begin q = hi; ovl = 1; end
            else if (q < lo) begin q = lo; ovl = 1; end
            if (m_dep[pc] != 0 && li + MAC_LAT > t) t = li + MAC_LAT;
            li = t;
            t++;
            if (m_dst[pc] != 0) mrf[m_dst[pc]] = q[34:0];
            if (m_last[pc] != 0 || pc == 31) break;
        end
        cyc = li + MAC_LAT + 1;
    endtask

    task automatic run(input int restart_at, input int rej_at,
                       output int ncyc, output int ndone, output int nrej);
        ncyc = -1; ndone = 0; nrej = 0;
        start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick;
            start = (i == restart_at);
            rf_we = (i == rej_at); rf_waddr = 4'd3; rf_wdata = 35'h1_2345_6789;
            if (wr_rej) nrej++;
            if (done) begin
                ndone++;
                if (ncyc < 0) ncyc = i;
            end
            if (ncyc >= 0 && i >= ncyc + 2) break;
        end
        start = 1'b0; rf_we = 1'b0;
    endtask

    task automatic pulse_clr;
        clr_ovl = 1'b1; tick; clr_ovl = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic signed [34:0] v;
        for (int i = 0; i < 16; i++) begin
            get_rf(i, v);
            n_checks++;
            if (v !== mrf[i]) begin
                n_fail++;
                $display("FAIL %s rf%0d: got %0d expected %0d", tag, i, v, mrf[i]);
            end
        end
    endtask

    function automatic logic [34:0] rand_val();
        logic [63:0] r;
        longint sm;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) return r[34:0];
        sm = longint'($urandom_range(0, 8*16777216)) - 4*ONE;
        return 35'(sm);
    endfunction

    task automatic test_reset;
        logic signed [34:0] v;
        rst = 1'b1; enable = 1'b1; start = 1'b0; prog_we = 1'b0; rf_we = 1'b0; clr_ovl = 1'b0;
        prog_addr = '0; prog_wdata = '0; rf_waddr = '0; rf_wdata = '0; rf_raddr = '0;
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        tick; tick;
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (wr_rej !== 1'b0) begin n_fail++; $display("FAIL reset_wr_rej: got %b expected 0", wr_rej); end
        n_checks++; if (overload !== 1'b0) begin n_fail++; $display("FAIL reset_overload: got %b expected 0", overload); end
        n_checks++; if (cyc_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cyc_cnt: got %0d expected 0", cyc_cnt); end
        check_regs("reset");
        write_rf(0, 35'd12345);
        get_rf(0, v);
        n_checks++; if (v !== 35'sd0) begin n_fail++; $display("FAIL rf0_write_discard: got %0d expected 0", v); end
    endtask

    task automatic test_single;
        int ncyc, nd, nr, ec; bit eo;
        logic signed [34:0] v;
        write_rf(1, 35'(2*ONE)); write_rf(2, 35'(ONE)); write_rf(3, 35'(ONE/2)); write_rf(4, 35'(ONE));
        set_instr(0, 1, 0, 5, 1, 2, 3, 4, 0, 0, 0, 0);
        model_run(ec, eo);
        run(0, 0, ncyc, nd, nr);
        get_rf(5, v);
        n_checks++; if (v !== 35'sd41943040) begin n_fail++; $display("FAIL single_rf5: got %0d expected 41943040", v); end
        n_checks++; if (ncyc !== 12) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 12", ncyc); end
        n_checks++; if (cyc_cnt !== 16'(ec)) begin n_fail++; $display("FAIL single_cyc_cnt: got %0d expected %0d", cyc_cnt, ec); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected 1", nd); end
        check_regs("single");
        last_cyc = ec;
    endtask

    task automatic test_dep;
        int ncyc, nd, nr, ec; bit eo;
        logic signed [34:0] v;
        set_instr(0, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0);
        set_instr(1, 1, 1, 6, 5, 3, 0, 0, 0, 0, 0, 0);
        model_run(ec, eo);
        run(0, 0, ncyc, nd, nr);
        get_rf(6, v);
        n_checks++; if (v !== 35'(ONE)) begin n_fail++; $display("FAIL dep_rf6: got %0d expected %0d", v, ONE); end
        n_checks++; if (ncyc !== 22 || cyc_cnt !== 16'(ec)) begin n_fail++; $display("FAIL dep_cyc_cnt: got %0d/%0d expected 22/%0d", ncyc, cyc_cnt, ec); end
        last_cyc = ec;
    endtask

    task automatic test_saturation;
        int ncyc, nd, nr, ec; bit eo;
        logic signed [34:0] v;
        write_rf(1, 35'h3_FFFF_FFFF); write_rf(2, 35'(4*ONE)); write_rf(3, 35'h4_0000_0000);
        set_instr(0, 1, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0);
        model_run(ec, eo);
        run(0, 0, ncyc, nd, nr);
        get_rf(7, v);
        n_checks++; if (v !== 35'h3_FFFF_FFFF) begin n_fail++; $display("FAIL sat_pos_rf7: got %0d expected %0d", v, 35'h3_FFFF_FFFF); end
        n_checks++; if (overload !== eo) begin n_fail++; $display("FAIL sat_pos_overload: got %b expected %b", overload, eo); end
        pulse_clr;
        n_checks++; if (overload !== 1'b0) begin n_fail++; $display("FAIL sat_clr: got %b expected 0", overload); end
        set_instr(0, 1, 0, 8, 3, 2, 0, 0, 0, 0, 0, 0);
        model_run(ec, eo);
        run(0, 0, ncyc, nd, nr);
        check_regs("sat_neg");
        n_checks++; if (overload !== 1'b1) begin n_fail++; $display("FAIL sat_neg_overload: got %b expected 1", overload); end
        pulse_clr;
        last_cyc = ec;
    endtask

    task automatic test_wr_rej;
        int ncyc, nd, nr, ec; bit eo;
        write_rf(1, 35'(2*ONE)); write_rf(2, 35'(ONE)); write_rf(3, 35'(ONE/2)); write_rf(4, 35'(ONE));
        set_instr(0, 1, 0, 5, 1, 2, 3, 4, 0, 0, 0, 0);
        model_run(ec, eo);
        run(0, 3, ncyc, nd, nr);
        n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL wr_rej_pulses: got %0d expected 1", nr); end
        check_regs("wr_rej");
        n_checks++; if (cyc_cnt !== 16'(ec)) begin n_fail++; $display("FAIL wr_rej_cyc_cnt: got %0d expected %0d", cyc_cnt, ec); end
        last_cyc = ec;
    endtask

    task automatic test_abort;
        int nd;
        write_rf(5, 35'd777);
        set_instr(0, 1, 0, 5, 1, 2, 3, 4, 0, 0, 0, 0);
        nd = 0;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            start = 1'b0;
            if (done) nd++;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        enable = 1'b0;
        tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b expected 0", busy); end
        for (int i = 0; i < 14; i++) begin
            tick;
            if (done) nd++;
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (done || busy) nd++;
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d activity cycles expected 0", nd); end
        n_checks++; if (cyc_cnt !== 16'(last_cyc)) begin n_fail++; $display("FAIL abort_cyc_cnt: got %0d expected %0d", cyc_cnt, last_cyc); end
        check_regs("abort");
    endtask

    task automatic test_back_to_back;
        int ncyc, nd, nr, ec, extra; bit eo;
        for (int i = 1; i <= 4; i++) write_rf(i, 35'(longint'($urandom_range(0, 4*16777216)) - 2*ONE));
        set_instr(0, 0, 0, 8, 1, 2, 0, 0, 0, 0, 0, 0);
        set_instr(1, 0, 0, 9, 3, 4, 1, 1, 0, 0, 0, 0);
        set_instr(2, 1, 0, 10, 2, 3, 4, 4, 1, 3, 0, 0);
        model_run(ec, eo);
        run(3, 0, ncyc, nd, nr);
        n_checks++; if (ec !== 14 || cyc_cnt !== 16'(ec)) begin n_fail++; $display("FAIL b2b_cyc_cnt: got %0d expected 14 (model %0d)", cyc_cnt, ec); end
        check_regs("b2b");
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (busy || done) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_restart_ignored: got %0d busy cycles expected 0", extra); end
        last_cyc = ec;
    endtask

    task automatic test_full_program;
        int ncyc, nd, nr, ec; bit eo;
        for (int i = 1; i <= 8; i++) write_rf(i, 35'(longint'($urandom_range(0, 4*16777216)) - 2*ONE));
        for (int pc = 0; pc < 32; pc++)
            set_instr(pc, 0, 0, 9 + (pc % 7), 1 + (pc % 8), 8 - (pc % 8), pc % 5, 2, 0, 0, 0, 0);
        model_run(ec, eo);
        run(0, 0, ncyc, nd, nr);
        n_checks++; if (ec !== 43 || ncyc !== 43 || cyc_cnt !== 16'(ec)) begin n_fail++; $display("FAIL full_prog_cyc: got %0d/%0d expected 43 (model %0d)", ncyc, cyc_cnt, ec); end
        check_regs("full_prog");
        pulse_clr;
        last_cyc = ec;
    endtask

    task automatic test_random;
        int ncyc, nd, nr, ec, len; bit eo;
        for (int it = 0; it < 20; it++) begin
            for (int i = 1; i < 16; i++) write_rf(i, rand_val());
            pulse_clr;
            len = $urandom_range(1, 6);
            for (int pc = 0; pc < len; pc++)
                set_instr(pc, (pc == len-1) ? 1 : 0, $urandom_range(0, 1), $urandom_range(9, 15),
                          $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8),
                          $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
            model_run(ec, eo);
            run(0, 0, ncyc, nd, nr);
            n_checks++; if (ncyc !== ec || cyc_cnt !== 16'(ec)) begin n_fail++; $display("FAIL rand%0d_cyc: got %0d/%0d expected %0d", it, ncyc, cyc_cnt, ec); end
            n_checks++; if (overload !== eo) begin n_fail++; $display("FAIL rand%0d_overload: got %b expected %b", it, overload, eo); end
            check_regs("rand");
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_dep;
        test_saturation;
        test_wr_rej;
        test_abort;
        test_back_to_back;
        test_full_program;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
